// File: rtl/out_lj_scheduler_if.sv
// out_lj_scheduler_if: sample-feed and serializer bus of the LJ frame scheduler.
//   Upstream side : in_valid, in_left, in_right (to scheduler), in_ready (from scheduler).
//   Serializer side: ser_start, ser_left, ser_right (from scheduler), ser_data_ready (to it).
// master modport = scheduler, slave modport = surrounding source/serializer.
interface out_lj_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_left;
  logic [DATA_WIDTH-1:0] in_right;
  logic                  in_ready;
  logic                  ser_start;
  logic [DATA_WIDTH-1:0] ser_left;
  logic [DATA_WIDTH-1:0] ser_right;
  logic                  ser_data_ready;

  modport master (
    input  in_valid, in_left, in_right, ser_data_ready,
    output in_ready, ser_start, ser_left, ser_right
  );

  modport slave (
    output in_valid, in_left, in_right, ser_data_ready,
    input  in_ready, ser_start, ser_left, ser_right
  );
endinterface

// File: rtl/out_lj_scheduler.sv
// out_lj_scheduler: frame scheduler and sample-feed controller for the left-justified DAC
// serializer (BCLK domain). Pulls one stereo pair per frame, holds it for the whole frame,
// fires a one-cycle serializer start on a fixed FRAME_BCLKS grid and checks completion.
//
// Ports:
//   i_bclk           bit clock, the only clock
//   i_reset          synchronous active-high reset
//   i_enable         level-sensitive run request, honoured only at the load cycle while running
//   io_bus           sample source + serializer bus (master modport)
//   o_busy           high while in RUN
//   o_underrun_count saturating count of frames with no sample available
//   o_ser_error      sticky: serializer not done by the next frame boundary
//
// Build option: OUT_LJ_SCHED_HOLD_EN defined -> repeat the last sample on underrun,
// otherwise underrun frames play silence (zero).
module out_lj_scheduler #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned FRAME_BCLKS = 64,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 i_bclk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  out_lj_scheduler_if.master   io_bus,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_underrun_count,
  output logic                 o_ser_error
);

  localparam int unsigned FcntW = (FRAME_BCLKS > 1) ? $clog2(FRAME_BCLKS) : 1;
  localparam logic [FcntW-1:0] LastFcnt = FcntW'(FRAME_BCLKS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                r_state, w_state_d;
  logic [FcntW-1:0]      r_fcnt, w_fcnt_d;
  logic                  r_first, w_first_d;   // next load cycle is the first of this run
  logic [DATA_WIDTH-1:0] r_left, w_left_d;
  logic [DATA_WIDTH-1:0] r_right, w_right_d;
  logic [CNT_WIDTH-1:0]  r_underrun, w_underrun_d;
  logic                  r_error, w_error_d;
  logic                  w_in_ready;
  logic                  w_ser_start;

  always_ff @(posedge i_bclk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_fcnt     <= '0;
      r_first    <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
      r_underrun <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_fcnt     <= w_fcnt_d;
      r_first    <= w_first_d;
      r_left     <= w_left_d;
      r_right    <= w_right_d;
      r_underrun <= w_underrun_d;
      r_error    <= w_error_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_fcnt_d     = r_fcnt;
    w_first_d    = r_first;
    w_left_d     = r_left;
    w_right_d    = r_right;
    w_underrun_d = r_underrun;
    w_error_d    = r_error;
    w_in_ready   = 1'b0;
    w_ser_start  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          // Start on a load cycle so the first frame is fed immediately.
          w_state_d = StRun;
          w_fcnt_d  = LastFcnt;
          w_first_d = 1'b1;
        end
      end
      StRun: begin
        // fcnt==0 in RUN only ever follows an enabled load cycle.
        w_ser_start = (r_fcnt == '0);
        if (r_fcnt == LastFcnt) begin
          w_fcnt_d  = '0;
          w_first_d = 1'b0;
          // Serializer has no reset: its flag is meaningless before our first start.
          if (!r_first && !io_bus.ser_data_ready) begin
            w_error_d = 1'b1;
          end
          if (i_enable) begin
            w_in_ready = 1'b1;
            if (io_bus.in_valid) begin
              w_left_d  = io_bus.in_left;
              w_right_d = io_bus.in_right;
            end else begin
              if (r_underrun != '1) begin
                w_underrun_d = r_underrun + CNT_WIDTH'(1);
              end
`ifdef OUT_LJ_SCHED_HOLD_EN
              w_left_d  = r_left;
              w_right_d = r_right;
`else
              w_left_d  = '0;
              w_right_d = '0;
`endif
            end
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_fcnt_d = r_fcnt + FcntW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.ser_start = w_ser_start;
  assign io_bus.ser_left  = r_left;
  assign io_bus.ser_right = r_right;

  assign o_busy           = (r_state == StRun);
  assign o_underrun_count = r_underrun;
  assign o_ser_error      = r_error;

endmodule

// File: tb/tb_out_lj_scheduler.sv
module tb_out_lj_scheduler;
  localparam int unsigned DW = 24;
  localparam int unsigned FB = 64;

  logic bclk = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  always #5 bclk = ~bclk;

  out_lj_scheduler_if #(.DATA_WIDTH(DW)) sif ();
  out_lj_scheduler_if #(.DATA_WIDTH(DW)) sif2 ();

  logic        busy, err, busy2, err2;
  logic [15:0] unr;
  logic [1:0]  unr2;

  out_lj_scheduler #(.DATA_WIDTH(DW), .FRAME_BCLKS(FB), .CNT_WIDTH(16)) dut (
    .i_bclk(bclk), .i_reset(rst), .i_enable(en), .io_bus(sif),
    .o_busy(busy), .o_underrun_count(unr), .o_ser_error(err)
  );

  // Narrow-counter instance sharing all stimulus, for the saturation check.
  out_lj_scheduler #(.DATA_WIDTH(DW), .FRAME_BCLKS(FB), .CNT_WIDTH(2)) dut2 (
    .i_bclk(bclk), .i_reset(rst), .i_enable(en), .io_bus(sif2),
    .o_busy(busy2), .o_underrun_count(unr2), .o_ser_error(err2)
  );

  assign sif2.in_valid       = sif.in_valid;
  assign sif2.in_left        = sif.in_left;
  assign sif2.in_right       = sif.in_right;
  assign sif2.ser_data_ready = sif.ser_data_ready;

  // Serializer model: ready drops on start, rises 2*DW cycles after start.
  logic m_rdy    = 1'b0;
  int   m_cnt    = 0;
  logic hold_low = 1'b0;
  always @(posedge bclk) begin
    if (sif.ser_start) begin
      m_cnt <= 2 * DW - 1;
      m_rdy <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_rdy <= 1'b1;
    end
  end
  assign sif.ser_data_ready = m_rdy & ~hold_low;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;
  pair_t exp_q[$];

  typedef struct {
    logic          valid;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    int unsigned   eunr;
  } vec_t;
  vec_t vt[5];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_start = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance one cycle, then compare any start pulse against the scoreboard.
  task automatic step();
    pair_t e;
    @(posedge bclk);
    #1;
    cyc++;
    if (sif.ser_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start: got ser_start=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_ser_left", 64'(sif.ser_left), 64'(e.l));
        check("sb_ser_right", 64'(sif.ser_right), 64'(e.r));
      end
      if (last_start >= 0) check("start_gap", 64'(cyc - last_start), 64'(FB));
      last_start = cyc;
    end
    if (busy !== 1'b1) last_start = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    sif.in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 64'(sif.in_ready), 64'd0);
    check({tag, "_ser_start"}, 64'(sif.ser_start), 64'd0);
    check({tag, "_ser_left"}, 64'(sif.ser_left), 64'd0);
    check({tag, "_ser_right"}, 64'(sif.ser_right), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_underrun"}, 64'(unr), 64'd0);
    check({tag, "_ser_error"}, 64'(err), 64'd0);
  endtask

  // From a start cycle (fcnt 0) to the next load cycle, with junk on the input bus.
  task automatic mid_frame(input logic [DW-1:0] el, input logic [DW-1:0] er,
                           input int drop_at, input string tag);
    logic ok;
    ok = 1'b1;
    for (int k = 1; k <= int'(FB) - 1; k++) begin
      sif.in_valid = 1'b1;
      sif.in_left  = DW'($urandom);
      sif.in_right = DW'($urandom);
      step();
      if (k < int'(FB) - 1 && sif.in_ready !== 1'b0) ok = 1'b0;
      if (sif.ser_start !== 1'b0 || sif.ser_left !== el || sif.ser_right !== er) ok = 1'b0;
      if (k == drop_at) en = 1'b0;
    end
    sif.in_valid = 1'b0;
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] hl2, hr2, hl4, hr4;
`ifdef OUT_LJ_SCHED_HOLD_EN
    hl2 = 24'h111111; hr2 = 24'h222222;
    hl4 = 24'h7FFFFF; hr4 = 24'h800000;
`else
    hl2 = '0; hr2 = '0;
    hl4 = '0; hr4 = '0;
`endif
    vt[0] = '{1'b1, 24'hABCDEF, 24'h123456, 24'hABCDEF, 24'h123456, 0};
    vt[1] = '{1'b1, 24'h111111, 24'h222222, 24'h111111, 24'h222222, 0};
    vt[2] = '{1'b0, 24'h5A5A5A, 24'hA5A5A5, hl2, hr2, 1};
    vt[3] = '{1'b1, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 1};
    vt[4] = '{1'b0, 24'h5A5A5A, 24'hA5A5A5, hl4, hr4, 2};

    sif.in_valid = 1'b0;
    sif.in_left  = '0;
    sif.in_right = '0;

    // Reset state
    do_reset();
    check_reset("rst");

    // Table-driven frames: enable -> load cycle next
    en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      sif.in_valid = vt[i].valid;
      sif.in_left  = vt[i].l;
      sif.in_right = vt[i].r;
      check("load_in_ready", 64'(sif.in_ready), 64'd1);
      check("load_busy", 64'(busy), 64'd1);
      exp_q.push_back('{vt[i].el, vt[i].er});
      step();
      check("frame_ser_start", 64'(sif.ser_start), 64'd1);
      check("frame_underrun", 64'(unr), 64'(vt[i].eunr));
      mid_frame(vt[i].el, vt[i].er, -1, "frame_hold");
    end
    check("err_normal", 64'(err), 64'd0);

    // Disable mid-frame at fcnt 10: frame completes, no transfer at the last load
    sif.in_valid = 1'b1;
    sif.in_left  = 24'h55AA55;
    sif.in_right = 24'hAA55AA;
    exp_q.push_back('{24'h55AA55, 24'hAA55AA});
    step();
    check("pre_disable_start", 64'(sif.ser_start), 64'd1);
    mid_frame(24'h55AA55, 24'hAA55AA, 10, "disable_frame_hold");
    check("disable_load_in_ready", 64'(sif.in_ready), 64'd0);
    check("disable_load_busy", 64'(busy), 64'd1);
    sif.in_valid = 1'b1;
    sif.in_left  = 24'h999999;
    sif.in_right = 24'h999999;
    step();
    check("disable_busy_low", 64'(busy), 64'd0);
    check("disable_no_start", 64'(sif.ser_start), 64'd0);
    check("disable_no_capture", 64'(sif.ser_left), 64'h55AA55);
    sif.in_valid = 1'b0;
    repeat (70) step();
    check("disable_idle_busy", 64'(busy), 64'd0);
    check("disable_queue_empty", 64'(exp_q.size()), 64'd0);

    // Serializer stuck not-ready: first load exempt, second flags, sticky
    do_reset();
    hold_low = 1'b1;
    en = 1'b1;
    step();
    sif.in_valid = 1'b1;
    sif.in_left  = 24'h000001;
    sif.in_right = 24'h000002;
    exp_q.push_back('{24'h000001, 24'h000002});
    step();
    check("err_first_exempt", 64'(err), 64'd0);
    mid_frame(24'h000001, 24'h000002, -1, "err_frame_hold");
    check("err_before_second_edge", 64'(err), 64'd0);
    sif.in_valid = 1'b1;
    sif.in_left  = 24'h000003;
    sif.in_right = 24'h000004;
    exp_q.push_back('{24'h000003, 24'h000004});
    step();
    check("err_second_load", 64'(err), 64'd1);
    en = 1'b0;
    mid_frame(24'h000003, 24'h000004, -1, "err_frame_hold2");
    step();
    check("err_after_disable_busy", 64'(busy), 64'd0);
    repeat (20) step();
    check("err_sticky", 64'(err), 64'd1);
    do_reset();
    check("err_cleared_by_reset", 64'(err), 64'd0);
    hold_low = 1'b0;

    // Reset in a load cycle cancels the pending start
    en = 1'b1;
    step();
    sif.in_valid = 1'b1;
    sif.in_left  = 24'h13579B;
    sif.in_right = 24'h2468AC;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sif.in_valid = 1'b0;
    check("rst_load_no_start", 64'(sif.ser_start), 64'd0);
    check("rst_load_no_capture", 64'(sif.ser_left), 64'd0);
    check("rst_load_busy", 64'(busy), 64'd0);

    // Reset at fcnt 30 with live data and an underrun on the books
    step();
    sif.in_valid = 1'b0;
    exp_q.push_back('{24'h0, 24'h0});
    step();
    mid_frame(24'h0, 24'h0, -1, "rstmid_frame1");
    sif.in_valid = 1'b1;
    sif.in_left  = 24'hABCDEF;
    sif.in_right = 24'h123456;
    exp_q.push_back('{24'hABCDEF, 24'h123456});
    step();
    sif.in_valid = 1'b0;
    check("rstmid_pre_underrun", 64'(unr), 64'd1);
    repeat (30) step();
    rst = 1'b1;
    hold_low = 1'b1;
    step();
    rst = 1'b0;
    check_reset("rstmid");
    step();
    check("rearm_load_in_ready", 64'(sif.in_ready), 64'd1);
    sif.in_valid = 1'b1;
    sif.in_left  = 24'h2468AC;
    sif.in_right = 24'h13579B;
    exp_q.push_back('{24'h2468AC, 24'h13579B});
    step();
    sif.in_valid = 1'b0;
    check("rearm_start", 64'(sif.ser_start), 64'd1);
    check("rearm_err_exempt", 64'(err), 64'd0);

    // Saturation: five consecutive underruns on both counter widths
    do_reset();
    hold_low = 1'b0;
    en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      sif.in_valid = 1'b0;
      exp_q.push_back('{24'h0, 24'h0});
      step();
      check("sat_unr16", 64'(unr), 64'(i + 1));
      check("sat_unr2", 64'(unr2), 64'((i + 1 > 3) ? 3 : i + 1));
      if (i == 4) en = 1'b0;
      mid_frame(24'h0, 24'h0, -1, "sat_frame_hold");
    end
    step();
    check("sat_final_unr2", 64'(unr2), 64'd3);
    check("sat_final_busy", 64'(busy), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/out_lj_scheduler.md
# out_lj_scheduler

Frame scheduler and sample-feed controller for the left-justified DAC serializer. It pulls stereo samples from an upstream valid/ready source once per audio frame and holds them stable for the whole frame. It fires the serializer's one-cycle `start` on a fixed BCLK-count frame grid and checks the serializer's `data_ready` completion flag. It sits between the sample source (FIFO/mixer) and the serializer, in the BCLK domain.

## Interface
- `DATA_WIDTH`, 24, sample width per channel; must match the serializer.
- `FRAME_BCLKS`, 64, BCLK cycles per stereo frame; legal range FRAME_BCLKS ≥ 2*DATA_WIDTH+1.
- `CNT_WIDTH`, 16, width of the underrun counter.

- `BCLK`  in  1  bit clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; level-sensitive.
- `in_valid`  in  1  upstream sample pair available.
- `in_left`  in  DATA_WIDTH  upstream left sample.
- `in_right`  in  DATA_WIDTH  upstream right sample.
- `in_ready`  out  1  sample accepted this cycle when in_valid=1.
- `ser_start`  out  1  one-cycle start pulse to the serializer.
- `ser_left`  out  DATA_WIDTH  left data to the serializer, stable for the whole frame.
- `ser_right`  out  DATA_WIDTH  right data to the serializer, stable for the whole frame.
- `ser_data_ready`  in  1  serializer completion flag.
- `busy`  out  1  scheduler in RUN state.
- `underrun_count`  out  CNT_WIDTH  saturating count of frames with no sample available.
- `ser_error`  out  1  sticky flag: serializer had not completed by the next frame boundary.

## Operation
- FSM states:
  - IDLE: all pulses are 0.
  - RUN: the frame counter `fcnt` (0..FRAME_BCLKS-1) increments every cycle and wraps to 0.
- IDLE→RUN: on the edge where enable=1 is sampled. `fcnt` is set to FRAME_BCLKS-1, so the next cycle is a load cycle.
- Load cycle: the RUN cycle where fcnt==FRAME_BCLKS-1.
  - If enable=1: in_ready=1 for that single cycle only.
  - If in_valid=1: at the closing edge, capture in_left/in_right into ser_left/ser_right.
  - If in_valid=0 (underrun): underrun_count increments, saturating at all-ones; data is handled per Configuration.
  - Next cycle (fcnt==0): ser_start=1 for exactly one cycle.
- Disable: enable=0 sampled in the load cycle.
  - in_ready stays 0, no capture, no ser_start.
  - Go to IDLE at that edge. The current frame always completes.
  - enable dropping at any other fcnt has no effect until the load cycle.
- Completion check: in every load cycle except the first after entering RUN, if ser_data_ready=0 then ser_error←1. ser_error clears only on reset.
- The first-frame exemption exists because the serializer has no reset, so its ready flag may be stale or undefined.
- ser_left/ser_right change only at load-cycle edges. The serializer reads them every bit, so they must never change mid-frame.

## Timing
- Reset values: in_ready=0, ser_start=0, ser_left=0, ser_right=0, busy=0, underrun_count=0, ser_error=0, state=IDLE, fcnt=0.
- Reset mid-frame:
  - All outputs return to their reset values in the cycle after the reset edge; any pending start is cancelled.
  - The serializer may finish its frame; this is ignored.
  - The first-frame check exemption re-arms.
- Latency:
  - enable sampled at edge E → in_ready high in cycle E+1 → ser_start high in cycle E+2.
  - Thereafter, ser_start pulses are exactly FRAME_BCLKS cycles apart.
- Serializer ready rises 2*DATA_WIDTH cycles after ser_start. With FRAME_BCLKS ≥ 2*DATA_WIDTH+1, it is high at the next load cycle.
- Simultaneous events in the load cycle:
  - enable=0 with in_valid=1: no transfer (in_ready=0).
  - Underrun and ser_error are evaluated independently.
- busy=1 exactly while in RUN, including the final load cycle.

## Configuration
- `OUT_LJ_SCHED_HOLD_EN` defined: on underrun, ser_left/ser_right keep the previous frame's sample (repeat last).
- Not defined: on underrun, ser_left/ser_right load 0 (silence).
- The underrun counter behaves identically in both builds.

## Test plan
- Enable with in_valid=1, in_left=24'hABCDEF, in_right=24'h123456 → in_ready one-cycle pulse, ser_start the next cycle, ser_left=24'hABCDEF held 64 cycles, next ser_start exactly 64 cycles later.
- in_valid=0 at the third load cycle → underrun_count 0→1, ser_start still issued. ser_left=0 without the macro; previous sample with OUT_LJ_SCHED_HOLD_EN.
- CNT_WIDTH=2, five consecutive underruns → underrun_count reads 3 and stays at 3.
- Drop enable at fcnt=10 → frame completes, in_ready=0 at the load cycle, busy falls after it, no further ser_start.
- Serializer model holding ser_data_ready=0 → ser_error=0 at the first load cycle, 1 at the second, stays 1 through disable; cleared only by reset.
- Assert reset at fcnt=30 → all outputs 0 the next cycle. Re-enable with a stale ser_data_ready=0 → no ser_error at the first load cycle.
